// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one byte-serial UART transmitter among three producers.
// Optional UART_ARB_PRIORITY_EN: producer 0 always wins; producers 1 and 2 alternate behind it.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES    = 5208,
  parameter int START_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  input  logic [7:0]  din2,
  output logic [2:0]  ack,
  output logic [2:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        err_timeout,
  output logic [15:0] byte_count
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int TO_W  = $clog2(START_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  // WAIT_BUSY is first evaluated two clocks after tx_start, so the timeout count ends two short.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       state_reg;
  logic [1:0]       ptr_reg;
  logic [1:0]       win_idx_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [2:0]       ack_reg;
  logic [2:0]       grant_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_start_reg;
  logic             err_reg;
  logic [15:0]      byte_count_reg;

  logic             win_valid;
  logic [1:0]       win_idx;
  logic [2:0]       win_onehot;
  logic [1:0]       ptr_next;
  logic [7:0]       din_arr [3];

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign win_onehot = 3'b001 << win_idx;

`ifdef UART_ARB_PRIORITY_EN
  logic [1:0] rr_first;
  logic [1:0] rr_second;

  // ptr only ever names producer 1 or 2; the reset value 0 behaves like 1.
  assign rr_first  = (ptr_reg == 2'd2) ? 2'd2 : 2'd1;
  assign rr_second = (ptr_reg == 2'd2) ? 2'd1 : 2'd2;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    if (req[0]) begin
      win_valid = 1'b1;
      win_idx   = 2'd0;
    end else if (req[rr_first]) begin
      win_valid = 1'b1;
      win_idx   = rr_first;
    end else if (req[rr_second]) begin
      win_valid = 1'b1;
      win_idx   = rr_second;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (win_idx_reg == 2'd1) ptr_next = 2'd2;
    else if (win_idx_reg == 2'd2) ptr_next = 2'd1;
  end
`else
  logic [2:0][1:0] cand;

  // cand[gi] is the producer searched at rank gi, starting from ptr.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rank
    logic [2:0] sum;
    assign sum      = {1'b0, ptr_reg} + 3'(gi);
    assign cand[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req[cand[k]]) begin
        win_valid = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  assign ptr_next = (win_idx_reg == 2'd2) ? 2'd0 : win_idx_reg + 2'd1;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= 2'd0;
      win_idx_reg    <= 2'd0;
      to_cnt_reg     <= '0;
      gap_cnt_reg    <= '0;
      ack_reg        <= 3'b000;
      grant_reg      <= 3'b000;
      tx_data_reg    <= 8'h00;
      tx_start_reg   <= 1'b0;
      err_reg        <= 1'b0;
      byte_count_reg <= 16'd0;
    end else begin
      ack_reg      <= 3'b000;
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (win_valid) begin
            tx_data_reg  <= din_arr[win_idx];
            grant_reg    <= win_onehot;
            ack_reg      <= win_onehot;
            tx_start_reg <= 1'b1;
            win_idx_reg  <= win_idx;
            state_reg    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          ptr_reg    <= ptr_next;
          to_cnt_reg <= '0;
          state_reg  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_reg <= S_WAIT_DONE;
          end else if (to_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            grant_reg <= 3'b000;
            state_reg <= S_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            byte_count_reg <= byte_count_reg + 16'd1;
            grant_reg      <= 3'b000;
            gap_cnt_reg    <= '0;
            state_reg      <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) state_reg <= S_IDLE;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_reg;
  assign grant       = grant_reg;
  assign tx_data     = tx_data_reg;
  assign tx_start    = tx_start_reg;
  assign err_timeout = err_reg;
  assign byte_count  = byte_count_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int GAP      = 4;
  localparam int TMO      = 16;
  localparam int BUSY_LEN = 20;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [7:0]  din0, din1, din2;
  logic [2:0]  ack;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        err_timeout;
  logic [15:0] byte_count;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2),
    .ack(ack), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .err_timeout(err_timeout), .byte_count(byte_count)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic model_en;
  int busy_left;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transmitter: busy rises the clock after tx_start and stays high BUSY_LEN clocks.
  always @(posedge sys_clk) begin
    if (rst) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (model_en && tx_start) begin
      tx_busy   <= 1'b1;
      busy_left <= BUSY_LEN - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  always @(negedge sys_clk) begin
    if (tx_start)
      $display("[TB] cyc=%0d start ack=%b grant=%b data=%h count=%0d", cyc, ack, grant, tx_data, byte_count);
    if (err_timeout)
      $display("[TB] cyc=%0d err_timeout grant=%b count=%0d", cyc, grant, byte_count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output logic [2:0] a, output int at);
    a  = 3'b000;
    at = -1000;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (ack != 3'b000) begin
        a  = ack;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_busy_fall(input int limit, output int at);
    logic seen_high;
    seen_high = 1'b0;
    at = -1000;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (tx_busy) seen_high = 1'b1;
      else if (seen_high) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] a;
    int t0, t1, f, te;
    int exp_idx [6];
    logic [7:0] din_val [3];

`ifdef UART_ARB_PRIORITY_EN
    exp_idx = '{0, 0, 0, 0, 0, 0};
`else
    exp_idx = '{0, 1, 2, 0, 1, 2};
`endif
    din_val = '{8'h10, 8'h21, 8'h32};

    rst = 1'b1; req = 3'b000; din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; model_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    check("rst_count", 32'(byte_count), 32'h0);
    rst = 1'b0;

    // Single request from producer 1, then a request held through the gap.
    @(negedge sys_clk);
    req = 3'b010; din1 = 8'h5A; t0 = cyc;
    wait_ack(10, a, t1);
    check("single_ack", 32'(a), 32'b010);
    check("single_latency", t1 - t0, 1);
    check("single_start", 32'(tx_start), 32'h1);
    check("single_data", 32'(tx_data), 32'h5A);
    req = 3'b000; din1 = 8'h00;
    wait_busy_fall(60, f);
    req = 3'b001; din0 = 8'hC3;
    @(negedge sys_clk);
    check("single_count", 32'(byte_count), 32'h1);
    check("single_data_hold", 32'(tx_data), 32'h5A);
    check("single_grant_clr", 32'(grant), 32'h0);
    wait_ack(20, a, t1);
    check("gap_ack_delay", t1 - f, GAP + 2);
    check("gap_ack", 32'(a), 32'b001);
    req = 3'b000;
    wait_busy_fall(60, f);

    // Round-robin fairness with all three requesting.
    do_reset();
    din0 = din_val[0]; din1 = din_val[1]; din2 = din_val[2];
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_ack(60, a, t1);
      check("rr_ack", 32'(a), 32'(3'b001 << exp_idx[i]));
      check("rr_data", 32'(tx_data), 32'(din_val[exp_idx[i]]));
    end
    req = 3'b000;
    wait_busy_fall(60, f);
    @(negedge sys_clk);
    check("rr_count", 32'(byte_count), 32'd6);

    // Start timeout with a silent transmitter.
    do_reset();
    model_en = 1'b0;
    req = 3'b001; din0 = 8'hA1;
    wait_ack(10, a, t0);
    check("to_ack", 32'(a), 32'b001);
    check("to_grant_held", 32'(grant), 32'b001);
    req = 3'b000;
    te = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (err_timeout) begin
        te = cyc;
        break;
      end
    end
    check("to_delay", te - t0, TMO);
    check("to_grant_clr", 32'(grant), 32'h0);
    check("to_count", 32'(byte_count), 32'h0);
    @(negedge sys_clk);
    check("to_pulse_len", 32'(err_timeout), 32'h0);
    model_en = 1'b1;
    req = 3'b010; din1 = 8'hB2;
    wait_ack(10, a, t1);
    check("to_next_ack", 32'(a), 32'b010);
    check("to_next_data", 32'(tx_data), 32'hB2);
    req = 3'b000;
    wait_busy_fall(60, f);
    @(negedge sys_clk);
    check("to_next_count", 32'(byte_count), 32'h1);

    // Reset while the transmitter is serialising.
    do_reset();
    req = 3'b001; din0 = 8'h44;
    wait_ack(10, a, t1);
    req = 3'b000;
    repeat (5) @(negedge sys_clk);
    check("mid_grant_busy", 32'(grant), 32'b001);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mid_ack", 32'(ack), 32'h0);
    check("mid_grant", 32'(grant), 32'h0);
    check("mid_tx_data", 32'(tx_data), 32'h0);
    check("mid_tx_start", 32'(tx_start), 32'h0);
    check("mid_err", 32'(err_timeout), 32'h0);
    check("mid_count", 32'(byte_count), 32'h0);
    req = 3'b100; din2 = 8'h77;
    wait_ack(10, a, t1);
    check("mid_next_ack", 32'(a), 32'b100);
    check("mid_next_data", 32'(tx_data), 32'h77);
    req = 3'b000;
    wait_busy_fall(60, f);
    @(negedge sys_clk);
    check("mid_next_count", 32'(byte_count), 32'h1);

    // Counter wrap, and a request raised during the gap.
    do_reset();
    force dut.byte_count_reg = 16'hFFFF;
    @(negedge sys_clk);
    release dut.byte_count_reg;
    @(negedge sys_clk);
    check("wrap_preload", 32'(byte_count), 32'hFFFF);
    req = 3'b010; din1 = 8'h99;
    wait_ack(10, a, t1);
    check("wrap_ack", 32'(a), 32'b010);
    req = 3'b000;
    wait_busy_fall(60, f);
    req = 3'b001; din0 = 8'h3C;
    @(negedge sys_clk);
    check("wrap_count", 32'(byte_count), 32'h0);
    wait_ack(20, a, t1);
    check("wrap_gap_delay", t1 - f, GAP + 2);
    check("wrap_gap_ack", 32'(a), 32'b001);
    req = 3'b000;
    wait_busy_fall(60, f);
    @(negedge sys_clk);
    check("wrap_count_next", 32'(byte_count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that lets three producers share the single byte-serial UART transmitter behind the HC05 Bluetooth link. Producers: 0 = RX echo, 1 = game events, 2 = status/score. Each producer offers a byte with a req/ack handshake. The arbiter latches the winning byte, fires the transmitter, and tracks it through completion. It then enforces an inter-byte gap before granting the next byte. It sits between the game logic and the UART transmitter inside the top level.

## Interface
- `GAP_CYCLES`, default 5208: idle clocks inserted after each byte completes; 0 means no gap.
- `START_TIMEOUT`, default 16: maximum clocks to wait for `tx_busy` to rise after `tx_start`.
- `sys_clk` in 1: system clock. One clock domain.
- `rst` in 1: synchronous reset, active-high.
- `req` in 3: per-producer request. Held high with `din_N` stable until that producer's `ack` bit pulses.
- `din0`, `din1`, `din2` in 8 each: producer bytes.
- `ack` out 3: one-cycle pulse to the granted producer; the byte has been taken.
- `grant` out 3: one-hot owner of the current transfer; held from the ack cycle until the transfer leaves WAIT_DONE.
- `tx_data` out 8: byte presented to the transmitter; stable from `tx_start` until the next grant.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_busy` in 1: transmitter is serialising. High after start, low when the stop bit is finished.
- `err_timeout` out 1: one-cycle pulse when `tx_busy` failed to rise.
- `byte_count` out 16: number of bytes completed. Wraps from 0xFFFF to 0.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**
  - With no `req` bit set: stay in IDLE.
  - Otherwise, select the winner by round-robin, searching from pointer `ptr` upward mod 3.
  - Latch `din_winner` into `tx_data`, set `grant`, go to LAUNCH.
- **LAUNCH** (exactly one cycle)
  - `tx_start`=1 and `ack[winner]`=1.
  - `ptr` ← winner+1 mod 3.
  - Go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY**
  - `tx_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments.
  - Counter reaches `START_TIMEOUT` → pulse `err_timeout`, clear `grant`, go to IDLE. No gap is inserted and `byte_count` is not incremented.
- **WAIT_DONE**
  - `tx_busy`=0 → increment `byte_count`, clear `grant`.
  - Then go to GAP, or directly to IDLE when `GAP_CYCLES`=0.
- **GAP**
  - Count `GAP_CYCLES` clocks, then go to IDLE.
  - `req` is ignored during GAP.
- Producer rules:
  - A producer that drops `req` before its ack is simply not served. No error is raised.
  - A dropped `req` has no effect once that producer is granted, because the byte is already latched.
  - A producer may hold `req` high across consecutive bytes. It is served again only after the other requesting producers have had their turn.
- Widths:
  - Timeout and gap counters are sized with `$clog2` of their parameter plus 1.
  - `byte_count` is unsigned with modulo wrap.

## Timing
- Reset values: `ack`=0, `grant`=0, `tx_data`=0x00, `tx_start`=0, `err_timeout`=0, `byte_count`=0; state=IDLE, `ptr`=0.
- All outputs are registered.
- Latency from `req` high in IDLE to `tx_start`/`ack` is 1 cycle: sampled at edge t, pulses during cycle t+1.
- `tx_start` is never asserted while the state is not LAUNCH. Only one transfer is ever outstanding.
- Simultaneous requests: exactly one `ack` bit per transfer. The others wait.
- `rst` in any state (including mid-gap or while `tx_busy`=1):
  - Takes effect at the next edge and returns to IDLE with the reset values above.
  - A byte already handed to the transmitter is abandoned and not counted.
- `tx_busy` high in IDLE is ignored. No start is issued until the state machine is in IDLE.
- Minimum spacing between `tx_start` pulses is 4 + `GAP_CYCLES` cycles:
  - 1 cycle LAUNCH.
  - At least 1 cycle in WAIT_BUSY.
  - At least 1 cycle in WAIT_DONE.
  - `GAP_CYCLES` cycles in GAP.
  - 1 cycle in IDLE.

## Configuration
- `UART_ARB_PRIORITY_EN`
  - Defined: producer 0 (RX echo) has fixed highest priority whenever its `req` is set. Producers 1 and 2 round-robin between themselves only when `req[0]`=0. `ptr` toggles only between 1 and 2.
  - Undefined: pure 3-way round-robin as described under Operation.

## Test plan
- **Single request.** `GAP_CYCLES`=4. Pulse `req`=3'b010 with `din1`=0x5A. Model the transmitter so `tx_busy` goes high 1 cycle after start and low 20 cycles later.
  - Required: `ack`=3'b010 and `tx_start` in the same cycle, one cycle after `req`.
  - Required: `tx_data`=0x5A, `byte_count`=1, IDLE reached 4 cycles after `tx_busy` falls.
- **Round-robin fairness.** Hold `req`=3'b111 for 6 bytes.
  - Required: grant order 0,1,2,0,1,2; `byte_count`=6.
  - With `UART_ARB_PRIORITY_EN` defined, the required order is 0,0,0,0,0,0.
- **Timeout.** Keep `tx_busy`=0 and request 3'b001.
  - Required: `err_timeout` pulses exactly 16 cycles after `tx_start`; `grant`=0; `byte_count` unchanged.
  - Required: a following request is launched normally.
- **Reset mid-transfer.** Assert `rst` for 1 cycle while in WAIT_DONE.
  - Required: all outputs at reset values on the next cycle; `ptr`=0; `byte_count`=0.
  - Required: the next `req`=3'b100 is granted to producer 2.
- **Wrap and gap.** Preload 65535 completed bytes via a force or a fast transmitter model, then send one more.
  - Required: `byte_count` wraps to 0.
  - Required: `req` asserted during GAP produces no `ack` until IDLE.
